// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the MEM-stage load/store
// port. It accepts a request, waits WAIT_STATES cycles, performs a word,
// halfword or byte access, and returns the result with a one-cycle Ack.
// Busy is high from acceptance through the Ack cycle and stalls the pipeline.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Datatype,
    output logic        Ack,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        AddrError
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // WAIT lasts WAIT_STATES cycles: the counter counts WAIT_STATES-1 down to 0.
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] DT_WORD  = 2'b00;
    localparam logic [1:0] DT_HALF  = 2'b01;
    localparam logic [1:0] DT_BYTES = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Captured request; only the address bits that select a byte are kept.
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic          re_q;
    logic [1:0]    dt_q;

    logic [31:0] read_data_q, read_data_d;
    logic        addr_error_q, addr_error_d;

    logic        accept;
    logic        enter_respond;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the memory size are ignored, so the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[31:AW+2];

    // Effective request: with zero wait states the access happens on the
    // accepting edge itself, before the capture registers hold the request.
    logic          in_idle;
    logic [AW+1:0] eff_addr;
    logic [31:0]   eff_wdata;
    logic          eff_we;
    logic          eff_re;
    logic [1:0]    eff_dt;

    assign in_idle   = (state_q == S_IDLE);
    assign eff_addr  = in_idle ? Addr[AW+1:0] : addr_q;
    assign eff_wdata = in_idle ? WriteData    : wdata_q;
    assign eff_we    = in_idle ? MemWrite     : we_q;
    assign eff_re    = in_idle ? MemRead      : re_q;
    assign eff_dt    = in_idle ? Datatype     : dt_q;

    logic [AW-1:0] word_idx;
    logic [4:0]    byte_ofs;
    logic [31:0]   mem_word;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;

    assign word_idx = eff_addr[AW+1:2];
    assign byte_ofs = {eff_addr[1:0], 3'b000};
    assign mem_word = mem[word_idx];
    assign byte_val = mem_word[byte_ofs +: 8];
    assign half_val = eff_addr[1] ? mem_word[31:16] : mem_word[15:0];

    // State register and iteration counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> WAIT (or RESPOND when there are no wait states) -> RESPOND -> IDLE.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d       = state_q;
        cnt_d         = cnt_q;
        accept        = 1'b0;
        enter_respond = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d       = S_RESPOND;
                        enter_respond = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d       = S_RESPOND;
                    enter_respond = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Capture the request on acceptance; later input changes are don't-care.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            dt_q    <= DT_WORD;
        end else if (accept) begin
            addr_q  <= Addr[AW+1:0];
            wdata_q <= WriteData;
            we_q    <= MemWrite;
            re_q    <= MemRead;
            dt_q    <= Datatype;
        end
    end

    // Access datapath: alignment check, store lane merge and load extraction.
    logic        misaligned;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic        mem_we;

    always_comb begin
        misaligned = 1'b0;
        merged     = mem_word;
        load_val   = mem_word;
        case (eff_dt)
            DT_WORD: begin
                misaligned = (eff_addr[1:0] != 2'b00);
                merged     = eff_wdata;
                load_val   = mem_word;
            end
            DT_HALF: begin
                misaligned = eff_addr[0];
                if (eff_addr[1]) merged[31:16] = eff_wdata[15:0];
                else             merged[15:0]  = eff_wdata[15:0];
                load_val = {{16{half_val[15]}}, half_val};
            end
            DT_BYTES: begin
                merged[byte_ofs +: 8] = eff_wdata[7:0];
                load_val = {{24{byte_val[7]}}, byte_val};
            end
            default: begin
                merged[byte_ofs +: 8] = eff_wdata[7:0];
                load_val = {24'd0, byte_val};
            end
        endcase
    end

    assign mem_we = enter_respond && eff_we && !misaligned;

    // Response registers update only on the edge entering RESPOND, otherwise hold.
    always_comb begin
        read_data_d  = read_data_q;
        addr_error_d = addr_error_q;
        if (enter_respond) begin
            addr_error_d = misaligned;
            read_data_d  = (eff_re && !eff_we && !misaligned) ? load_val : 32'd0;
        end
    end

    // Response output registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            read_data_q  <= 32'd0;
            addr_error_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            addr_error_q <= addr_error_d;
        end
    end

    // Storage array write port.
    // NOTE: the memory array has no reset; contents survive Rst, and a reset would prevent RAM inference.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[word_idx] <= merged;
        end
    end

    assign Ack       = (state_q == S_RESPOND);
    assign Busy      = (state_q != S_IDLE);
    assign ReadData  = read_data_q;
    assign AddrError = addr_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with zero wait states share the clock, reset and request fields.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req2 = 1'b0;
    logic        req0 = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [1:0]  datatype = 2'b00;

    logic        ack2, busy2, ae2;
    logic [31:0] rd2;
    logic        ack0, busy0, ae0;
    logic [31:0] rd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .Clk(clk), .Rst(rst), .Req(req2), .Addr(addr), .WriteData(wdata),
        .MemWrite(mem_write), .MemRead(mem_read), .Datatype(datatype),
        .Ack(ack2), .ReadData(rd2), .Busy(busy2), .AddrError(ae2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Rst(rst), .Req(req0), .Addr(addr), .WriteData(wdata),
        .MemWrite(mem_write), .MemRead(mem_read), .Datatype(datatype),
        .Ack(ack0), .ReadData(rd0), .Busy(busy0), .AddrError(ae0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; returns the response and the
    // number of cycles from the request cycle to the Ack cycle (0 = no Ack).
    task automatic access(input bit zw, input logic [31:0] a, input logic [31:0] wd,
                          input logic w, input logic r, input logic [1:0] d,
                          output logic [31:0] rd, output logic ae, output int lat);
        @(negedge clk);
        addr = a; wdata = wd; mem_write = w; mem_read = r; datatype = d;
        if (zw) req0 = 1'b1; else req2 = 1'b1;
        lat = 0; rd = 'x; ae = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req0 = 1'b0; req2 = 1'b0;
            if ((zw ? ack0 : ack2) === 1'b1) begin
                lat = k;
                rd  = zw ? rd0 : rd2;
                ae  = zw ? ae0 : ae2;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ae;
        int          lat;
        int          n_acks;
        logic [31:0] ack_rd;

        // Reset state.
        @(negedge clk);
        check("rst_ack", {31'd0, ack2}, 32'd0);
        check("rst_busy", {31'd0, busy2}, 32'd0);
        check("rst_rd", rd2, 32'd0);
        check("rst_ae", {31'd0, ae2}, 32'd0);
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Word store then word load.
        access(0, 32'h10, 32'hDEADBEEF, 1, 0, 2'b00, rd, ae, lat);
        check("st_word_lat", lat, 32'd3);
        check("st_word_ae", {31'd0, ae}, 32'd0);
        access(0, 32'h10, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("ld_word_lat", lat, 32'd3);
        check("ld_word", rd, 32'hDEADBEEF);
        check("ld_word_ae", {31'd0, ae}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("hold_rd", rd2, 32'hDEADBEEF);
        check("idle_busy", {31'd0, busy2}, 32'd0);

        // Byte and halfword lanes.
        access(0, 32'h11, 32'hAAAAAA55, 1, 0, 2'b10, rd, ae, lat);
        access(0, 32'h10, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("byte_merge", rd, 32'hDEAD55EF);
        access(0, 32'h13, 32'h0, 0, 1, 2'b10, rd, ae, lat);
        check("ld_byte_s", rd, 32'hFFFFFFDE);
        access(0, 32'h13, 32'h0, 0, 1, 2'b11, rd, ae, lat);
        check("ld_byte_u", rd, 32'h000000DE);
        access(0, 32'h12, 32'h0, 0, 1, 2'b01, rd, ae, lat);
        check("ld_half_hi", rd, 32'hFFFFDEAD);
        access(0, 32'h10, 32'h0, 0, 1, 2'b01, rd, ae, lat);
        check("ld_half_lo", rd, 32'h000055EF);
        access(0, 32'h12, 32'hFFFF7A5B, 1, 0, 2'b01, rd, ae, lat);
        access(0, 32'h10, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("half_merge", rd, 32'h7A5B55EF);

        // Misalignment, store+load together, no-op.
        access(0, 32'h20, 32'h11111111, 1, 0, 2'b00, rd, ae, lat);
        access(0, 32'h22, 32'h99999999, 1, 0, 2'b00, rd, ae, lat);
        check("mis_st_ae", {31'd0, ae}, 32'd1);
        check("mis_st_rd", rd, 32'd0);
        access(0, 32'h20, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("mis_no_write", rd, 32'h11111111);
        check("mis_clear_ae", {31'd0, ae}, 32'd0);
        access(0, 32'h30, 32'h77777777, 1, 1, 2'b00, rd, ae, lat);
        check("both_rd", rd, 32'd0);
        access(0, 32'h21, 32'h0, 0, 1, 2'b01, rd, ae, lat);
        check("mis_half_ae", {31'd0, ae}, 32'd1);
        check("mis_half_rd", rd, 32'd0);
        access(0, 32'h30, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("both_stored", rd, 32'h77777777);
        access(0, 32'h30, 32'h0, 0, 0, 2'b00, rd, ae, lat);
        check("noop_lat", lat, 32'd3);
        check("noop_rd", rd, 32'd0);

        // Request while busy is ignored.
        @(negedge clk);
        addr = 32'h10; mem_write = 1'b0; mem_read = 1'b1; datatype = 2'b00; req2 = 1'b1;
        @(negedge clk);
        check("busy_wait", {31'd0, busy2}, 32'd1);
        wdata = 32'hBAD00000; mem_write = 1'b1; mem_read = 1'b0;
        n_acks = 0; ack_rd = 'x;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ack2 === 1'b1) begin
                n_acks++;
                ack_rd = rd2;
                check("busy_at_ack", {31'd0, busy2}, 32'd1);
            end
            if (k == 2) req2 = 1'b0;
        end
        check("busy_one_ack", n_acks, 32'd1);
        check("busy_ack_rd", ack_rd, 32'h7A5B55EF);
        access(0, 32'h10, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("busy_not_serviced", rd, 32'h7A5B55EF);

        // Reset mid-operation aborts the store.
        access(0, 32'h40, 32'hAAAA0000, 1, 0, 2'b00, rd, ae, lat);
        access(0, 32'h40, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("pre_reset_ld", rd, 32'hAAAA0000);
        @(negedge clk);
        addr = 32'h40; wdata = 32'h12345678; mem_write = 1'b1; mem_read = 1'b0;
        datatype = 2'b00; req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy2}, 32'd0);
        check("midrst_rd", rd2, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_acks = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ack2 === 1'b1) n_acks++;
        end
        check("midrst_no_ack", n_acks, 32'd0);
        access(0, 32'h40, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("midrst_old", rd, 32'hAAAA0000);

        // Address wrap.
        access(0, 32'h1000, 32'h0BADCAFE, 1, 0, 2'b00, rd, ae, lat);
        access(0, 32'h0, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("wrap", rd, 32'h0BADCAFE);

        // Zero wait states.
        access(1, 32'h8, 32'h13572468, 1, 0, 2'b00, rd, ae, lat);
        check("zw_st_lat", lat, 32'd1);
        access(1, 32'h8, 32'h0, 0, 1, 2'b00, rd, ae, lat);
        check("zw_ld_lat", lat, 32'd1);
        check("zw_ld", rd, 32'h13572468);
        access(1, 32'hA, 32'h0, 0, 1, 2'b01, rd, ae, lat);
        check("zw_half", rd, 32'h00001357);

        // Back-to-back with Req held high: one access every two cycles.
        @(negedge clk);
        addr = 32'h8; mem_write = 1'b0; mem_read = 1'b1; datatype = 2'b00; req0 = 1'b1;
        n_acks = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ack0 === 1'b1) n_acks++;
        end
        req0 = 1'b0;
        check("zw_b2b_acks", n_acks, 32'd4);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder sitting on the far side of the pipeline's MEM-stage load/store port. The datapath issues a request; this block accepts it, inserts a fixed number of wait states, performs the word, halfword or byte access, and returns the result with a one-cycle acknowledge. `Busy` drives the datapath's pipeline stall.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; power of two.
- `WAIT_STATES`, 2: cycles spent in WAIT before the response; range 0–15.
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: reset, asynchronous, active-low.
- `Req` input 1: request strobe from the MEM stage.
- `Addr` input 32: byte address.
- `WriteData` input 32: store data; the low bits are used for half and byte stores.
- `MemWrite` input 1: store request.
- `MemRead` input 1: load request.
- `Datatype` input 2: access size.
  - 00 = word.
  - 01 = halfword, sign-extended on load.
  - 10 = byte, sign-extended on load.
  - 11 = byte, zero-extended on load.
- `Ack` output 1: one-cycle completion pulse.
- `ReadData` output 32: load result.
- `Busy` output 1: high from request acceptance through the Ack cycle inclusive.
- `AddrError` output 1: misaligned-access flag; valid only with `Ack`.

## Operation
- State machine: IDLE → WAIT → RESPOND → IDLE.
  - IDLE → WAIT when `Req`=1. If `WAIT_STATES`=0, IDLE → RESPOND directly.
  - WAIT holds for exactly `WAIT_STATES` cycles, using a 4-bit down-counter.
  - RESPOND lasts one cycle, then returns to IDLE.
- On acceptance in IDLE, all request inputs are captured into internal registers. Inputs are don't-care after acceptance.
- Word index is `Addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses wrap modulo the memory size.
- Byte order is little-endian: byte lane n = bits [8n+7:8n], selected by `Addr[1:0]`. Halfword lane is selected by `Addr[1]`.
- Alignment rules:
  - A word access requires `Addr[1:0]`=00.
  - A halfword access requires `Addr[0]`=0.
  - A misaligned access sets `AddrError`=1 with `Ack`, performs no write, and returns `ReadData`=0.
- Store:
  - The write commits on the edge that enters RESPOND.
  - Half and byte stores read-modify-write only the addressed lanes; other lanes are unchanged.
- Load:
  - The memory word is read using the captured address.
  - The addressed lane is extracted and extended per `Datatype`.
  - The result is registered into `ReadData` on the edge entering RESPOND.
- If `MemWrite`=`MemRead`=1, the store is performed and `ReadData`=0.
- If both are 0, the request is a no-op: `Ack` still pulses and `ReadData`=0.
- A `Req` arriving while `Busy`=1 is ignored, not queued.
- `ReadData` and `AddrError` hold their value until the next Ack.

## Timing
- Reset (`Rst`=0, asynchronous): state=IDLE, counter=0, `Ack`=0, `Busy`=0, `ReadData`=0, `AddrError`=0. Memory contents are not cleared.
- Reset mid-operation: if it asserts before the RESPOND entry edge, the pending store is aborted and no Ack is produced.
- Latency: `Req` sampled at edge T gives `Ack`=1 during cycle T+`WAIT_STATES`+1.
- `Busy` rises in the cycle after the accepting edge and falls after the Ack cycle.
- Back-to-back requests: `Req` held high continuously is re-accepted in the first IDLE cycle after Ack. Throughput is one access per `WAIT_STATES`+2 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset with `WAIT_STATES`=2:
  - Store word 0xDEADBEEF to 0x10, then load word from 0x10.
  - Required: `Ack` 3 cycles after each `Req`, `ReadData`=0xDEADBEEF, `AddrError`=0.
- Byte/half lanes: after the store above:
  - Store byte 0x55 to 0x11 → load word from 0x10 = 0xDEAD55EF.
  - Load byte signed from 0x13 = 0xFFFFFFDE.
  - Load byte unsigned from 0x13 = 0x000000DE.
  - Load half from 0x12 = 0xFFFFDEAD.
- Misalignment:
  - Word store to 0x22 → `AddrError`=1 and `ReadData`=0; a subsequent word load from 0x20 returns the prior contents.
  - Half load from 0x21 → `AddrError`=1.
- Busy/ignore: assert `Req` (load from 0x10) while `Busy`=1 → exactly one Ack per accepted request, and the second request is not serviced.
- Reset mid-operation: word store 0x12345678 to 0x40, then drop `Rst` during WAIT → `Ack` never pulses and a later load from 0x40 returns the old value.
- Wrap and zero-wait:
  - With `DEPTH_WORDS`=1024, store to 0x1000 then load 0x0000 → same data (address wrap).
  - With `WAIT_STATES`=0 → `Ack` one cycle after `Req`.
